// File: rtl/area_to_width.sv
// Recovers the 8-bit width that produced a given area by MSB-first binary search, one bit per clock.
// Optional build macro CIRCLE_AREA_EN: f(w) = w*w + floor(COEF*w*w/256); otherwise f(w) = w*w.
module area_to_width #(
    parameter int unsigned W_BITS = 8,
    parameter int unsigned A_BITS = 17
`ifdef CIRCLE_AREA_EN
    ,
    parameter int unsigned COEF   = 201
`endif
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [A_BITS-1:0] area,
    output logic              busy,
    output logic              done,
    output logic [W_BITS-1:0] width,
    output logic              exact,
    output logic              OV
);
    localparam int unsigned SQ_BITS = 2 * W_BITS;
    localparam int unsigned B_BITS  = $clog2(W_BITS);
    localparam int unsigned MAX_W   = (1 << W_BITS) - 1;
    localparam int unsigned SQ_MAX  = MAX_W * MAX_W;
`ifdef CIRCLE_AREA_EN
    localparam int unsigned P_BITS  = SQ_BITS + 8;
    localparam int unsigned A_MAX   = SQ_MAX + (COEF * SQ_MAX) / 256;
`else
    localparam int unsigned A_MAX   = SQ_MAX;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [A_BITS-1:0] area_q;
    logic [W_BITS-1:0] cand;
    logic [A_BITS-1:0] f_cand;
    logic [B_BITS-1:0] bit_idx;

    logic [W_BITS-1:0] trial;
    logic [A_BITS-1:0] f_trial;
    logic              fit;
    logic              last_bit;
    logic [W_BITS-1:0] cand_next;
    logic [A_BITS-1:0] f_cand_next;

    logic              accept;
    logic              step;
    logic              finish;

    // Area as a function of width, bit-exact with the forward area path
`ifdef CIRCLE_AREA_EN
    function automatic logic [A_BITS-1:0] area_of(input logic [W_BITS-1:0] w);
        logic [SQ_BITS-1:0] sq;
        logic [P_BITS-1:0]  prod;
        sq   = SQ_BITS'(w) * SQ_BITS'(w);
        prod = P_BITS'(COEF) * P_BITS'(sq);
        return A_BITS'(sq) + A_BITS'(prod >> 8);
    endfunction
`else
    function automatic logic [A_BITS-1:0] area_of(input logic [W_BITS-1:0] w);
        logic [SQ_BITS-1:0] sq;
        sq = SQ_BITS'(w) * SQ_BITS'(w);
        return A_BITS'(sq);
    endfunction
`endif

    // One search step: f(cand) is carried along so only the trial needs a multiplier
    always_comb begin
        trial       = cand | (W_BITS'(1) << bit_idx);
        f_trial     = area_of(trial);
        fit         = (f_trial <= area_q);
        last_bit    = (bit_idx == '0);
        cand_next   = fit ? trial : cand;
        f_cand_next = fit ? f_trial : f_cand;
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SEARCH;
            SEARCH:  if (last_bit) state_next = DONE;
            DONE:    state_next = start ? SEARCH : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state)
            IDLE:    accept = start;
            SEARCH:  begin
                step   = 1'b1;
                finish = last_bit;
            end
            DONE:    accept = start;
            default: ;
        endcase
    end

    // Search datapath and registered result/handshake outputs
    always_ff @(posedge clk) begin
        if (!Reset) begin
            area_q  <= '0;
            cand    <= '0;
            f_cand  <= '0;
            bit_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            width   <= '0;
            exact   <= 1'b0;
            OV      <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= finish;
            if (accept) begin
                area_q  <= area;
                cand    <= '0;
                f_cand  <= '0;
                bit_idx <= B_BITS'(W_BITS - 1);
            end else if (step) begin
                cand    <= cand_next;
                f_cand  <= f_cand_next;
                bit_idx <= bit_idx - B_BITS'(1);
            end
            if (finish) begin
                width <= cand_next;
                exact <= (f_cand_next == area_q);
                OV    <= (area_q > A_BITS'(A_MAX));
            end
        end
    end
endmodule

// File: tb/tb_area_to_width.sv
// Directed bench for area_to_width: result vectors, boundaries, handshake, mid-search reset, round trip.
module tb_area_to_width;
    logic        clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [16:0] area;
    logic        busy;
    logic        done;
    logic [7:0]  width;
    logic        exact;
    logic        OV;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef CIRCLE_AREA_EN
    int vec_area [5] = '{457, 456, 116079, 116080, 0};
    int vec_w    [5] = '{16, 15, 255, 255, 0};
    int vec_ex   [5] = '{1, 0, 1, 0, 1};
    int vec_ov   [5] = '{0, 0, 0, 1, 0};
`else
    int vec_area [5] = '{144, 150, 65025, 65026, 0};
    int vec_w    [5] = '{12, 12, 255, 255, 0};
    int vec_ex   [5] = '{1, 0, 1, 0, 1};
    int vec_ov   [5] = '{0, 0, 0, 1, 0};
`endif

    area_to_width dut (
        .clk   (clk),
        .Reset (Reset),
        .start (start),
        .area  (area),
        .busy  (busy),
        .done  (done),
        .width (width),
        .exact (exact),
        .OV    (OV)
    );

    always #5 clk = ~clk;

    function automatic int f_model(input int w);
`ifdef CIRCLE_AREA_EN
        return w * w + (201 * w * w) / 256;
`else
        return w * w;
`endif
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Start a search and wait (bounded) for done; lat counts edges after the accepting edge
    task automatic run(input int a, output int w, output int ex, output int ov, output int lat);
        area  = 17'(a);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        w  = int'(width);
        ex = int'(exact);
        ov = int'(OV);
    endtask

    initial begin
        int w, ex, ov, lat, dcount;
        Reset = 1'b0;
        start = 1'b0;
        area  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  int'(busy),  0);
        check("rst_done",  int'(done),  0);
        check("rst_width", int'(width), 0);
        check("rst_exact", int'(exact), 0);
        check("rst_ov",    int'(OV),    0);
        Reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run(vec_area[i], w, ex, ov, lat);
            check($sformatf("vec%0d_latency", i), lat, 8);
            check($sformatf("vec%0d_width", i), w, vec_w[i]);
            check($sformatf("vec%0d_exact", i), ex, vec_ex[i]);
            check($sformatf("vec%0d_ov", i), ov, vec_ov[i]);
        end
        @(posedge clk); #1;
        check("idle_after_done_busy", int'(busy), 0);
        check("idle_after_done_done", int'(done), 0);
        check("hold_width", int'(width), vec_w[4]);

        // Handshake: extra starts at k+3 and k+8 ignored, start at k+9 accepted
        area  = 17'(vec_area[0]);
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        dcount = 0;
        for (int e = 1; e <= 9; e++) begin
            start = (e == 3 || e == 8 || e == 9);
            area  = (e == 9) ? 17'(vec_area[2]) : 17'd0;
            @(posedge clk); #1;
            if (done) dcount++;
            if (e == 8) begin
                check("hs_done_k8", int'(done), 1);
                check("hs_width_k8", int'(width), vec_w[0]);
                check("hs_exact_k8", int'(exact), vec_ex[0]);
            end
            if (e == 9) begin
                check("hs_done_k9", int'(done), 0);
                check("hs_busy_k9", int'(busy), 1);
            end
        end
        start = 1'b0;
        area  = '0;
        check("hs_single_done", dcount, 1);
        dcount = 0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("hs_restart_done", int'(done), 1);
        check("hs_restart_pulses", dcount, 1);
        check("hs_restart_width", int'(width), vec_w[2]);
        check("hs_restart_exact", int'(exact), vec_ex[2]);
        @(posedge clk); #1;
        check("hs_done_fall", int'(done), 0);

        // Reset at edge k+4 aborts the search with no done pulse
        area  = 17'(vec_area[1]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            if (e == 4) Reset = 1'b0;
            @(posedge clk); #1;
        end
        check("mid_rst_busy",  int'(busy),  0);
        check("mid_rst_done",  int'(done),  0);
        check("mid_rst_width", int'(width), 0);
        check("mid_rst_exact", int'(exact), 0);
        check("mid_rst_ov",    int'(OV),    0);
        Reset  = 1'b1;
        dcount = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("mid_rst_no_done", dcount, 0);
        run(vec_area[1], w, ex, ov, lat);
        check("post_rst_latency", lat, 8);
        check("post_rst_width", w, vec_w[1]);
        check("post_rst_exact", ex, vec_ex[1]);

        // Round trip over every width
        for (int i = 0; i < 256; i++) begin
            run(f_model(i), w, ex, ov, lat);
            check($sformatf("rt%0d_width", i), w, i);
            check($sformatf("rt%0d_exact", i), ex, 1);
            check($sformatf("rt%0d_ov", i), ov, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
